uart_echo_master: RTL and testbench

- Parametrised successor to the single-byte UART test master. Bus master that drains bursts of up to BUF_DEPTH received bytes from the UART controller into a local buffer, shows a rolling history of recent bytes on the seg7 controller, then echoes the buffered bytes back out through the UART TX FIFO.
- Sits on the shared bus_if beside uart_controller and seg7_controller. Issues all transactions through an internal biu_master instance.

---
 rtl/uart_echo_pkg.sv | 20 ++
 rtl/bus_if.sv | 15 +
 rtl/biu_master.sv | 56 +++++
 rtl/uart_echo_buf.sv | 60 ++++++
 rtl/uart_echo_master.sv | 182 ++++++++++++++++++
 tb/tb_uart_echo_master.sv | 259 +++++++++++++++++++++++++
 6 files changed

// File: rtl/uart_echo_pkg.sv
// Shared types and helpers for the UART echo bus master.
package uart_echo_pkg;

  typedef enum logic [4:0] {
    RXST = 5'b00001,
    RXRD = 5'b00010,
    S7WR = 5'b00100,
    TXST = 5'b01000,
    TXWR = 5'b10000
  } state_t;

  localparam int unsigned UART_DATA_OFS = 0;
  localparam int unsigned UART_STAT_OFS = 8;

  // Never returns zero so a one-entry buffer still gets a real pointer.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/bus_if.sv
// Shared request/acknowledge system bus; the slave acks each request for one cycle.
interface bus_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ack;

  modport master (output req, output we, output addr, output wdata, input rdata, input ack);
  modport slave  (input req, input we, input addr, input wdata, output rdata, output ack);
endinterface

// File: rtl/biu_master.sv
// Bus interface unit: latches one request, holds it on the bus until acked.
module biu_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  n_rst,
  bus_if.master                 bus,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic                  data_valid,
  output logic                  busy
);

  logic                  req_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      data_in    <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (req_q) begin
        if (bus.ack) begin
          req_q <= 1'b0;
          if (!we_q) begin
            data_valid <= 1'b1;
            data_in    <= bus.rdata;
          end
        end
      end else if (en) begin
        req_q   <= 1'b1;
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= data_out;
      end
    end
  end

  assign busy      = req_q;
  assign bus.req   = req_q;
  assign bus.we    = we_q;
  assign bus.addr  = addr_q;
  assign bus.wdata = wdata_q;

endmodule

// File: rtl/uart_echo_buf.sv
// Small register FIFO holding received bytes until they are echoed.
module uart_echo_buf
  import uart_echo_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [ptr_width(DEPTH):0]  count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_echo_master.sv
// Drains UART RX bursts into a buffer, shows history on seg7, echoes bytes to TX.
// Define UART_ECHO_UPCASE_EN to fold lower-case ASCII to upper case on capture.
module uart_echo_master
  import uart_echo_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH    = 32,
  parameter int unsigned           DATA_WIDTH    = 32,
  parameter int unsigned           DATA_BITS     = 8,
  parameter int unsigned           BUF_DEPTH     = 4,
  parameter logic [ADDR_WIDTH-1:0] UART_BASE     = 32'hc0000000,
  parameter logic [ADDR_WIDTH-1:0] SEG7_BASE     = 32'hc0001000,
  parameter int unsigned           STAT_RXFE_BIT = 0,
  parameter int unsigned           STAT_TXFF_BIT = 1
) (
  input  logic        clk,
  input  logic        n_rst,
  bus_if.master       bus,
  output logic        o_busy,
  output logic [15:0] o_echo_count,
  output logic        o_overrun
);

  localparam int unsigned CW = ptr_width(BUF_DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] UART_DATA = UART_BASE + ADDR_WIDTH'(UART_DATA_OFS);
  localparam logic [ADDR_WIDTH-1:0] UART_STAT = UART_BASE + ADDR_WIDTH'(UART_STAT_OFS);

  state_t state_q, state_d;

  logic                  biu_en;
  logic                  biu_we;
  logic [ADDR_WIDTH-1:0] biu_addr;
  logic [DATA_WIDTH-1:0] biu_wdata;
  logic [DATA_WIDTH-1:0] biu_rdata;
  logic                  biu_valid;
  logic                  biu_busy;

  logic                  req_pending;
  logic                  rd_done;
  logic                  set_overrun;
  logic                  push;
  logic                  pop;
  logic [DATA_BITS-1:0]  rx_byte;
  logic [DATA_BITS-1:0]  push_byte;
  logic [DATA_BITS-1:0]  pop_byte;
  logic [CW-1:0]         count;
  logic                  full;
  logic                  empty;
  logic [DATA_WIDTH-1:0] history;
  logic                  unused_rdata;

  biu_master #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_biu (
    .clk        (clk),
    .n_rst      (n_rst),
    .bus        (bus),
    .en         (biu_en),
    .we         (biu_we),
    .addr       (biu_addr),
    .data_out   (biu_wdata),
    .data_in    (biu_rdata),
    .data_valid (biu_valid),
    .busy       (biu_busy)
  );

  uart_echo_buf #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_buf (
    .clk       (clk),
    .n_rst     (n_rst),
    .push      (push),
    .push_data (push_byte),
    .pop       (pop),
    .pop_data  (pop_byte),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Every state owns exactly one transaction, so a request is always wanted.
  assign biu_en       = !biu_busy && !req_pending;
  assign rd_done      = biu_valid && req_pending;
  assign rx_byte      = biu_rdata[DATA_BITS-1:0];
  assign unused_rdata = ^biu_rdata;
  assign o_busy       = (state_q != RXST) || !empty;

`ifdef UART_ECHO_UPCASE_EN
  always_comb begin
    push_byte = rx_byte;
    if (rx_byte >= DATA_BITS'(8'h61) && rx_byte <= DATA_BITS'(8'h7a)) begin
      push_byte[5] = 1'b0;
    end
  end
`else
  assign push_byte = rx_byte;
`endif

  always_comb begin
    state_d     = state_q;
    biu_we      = 1'b0;
    biu_addr    = UART_STAT;
    biu_wdata   = '0;
    push        = 1'b0;
    pop         = 1'b0;
    set_overrun = 1'b0;
    unique case (state_q)
      RXST: begin
        if (rd_done) begin
          if (!biu_rdata[STAT_RXFE_BIT]) begin
            if (!full) begin
              state_d = RXRD;
            end else begin
              set_overrun = 1'b1;
              state_d     = S7WR;
            end
          end else if (!empty) begin
            state_d = S7WR;
          end
        end
      end
      RXRD: begin
        biu_addr = UART_DATA;
        if (rd_done) begin
          push    = 1'b1;
          state_d = RXST;
        end
      end
      S7WR: begin
        biu_we    = 1'b1;
        biu_addr  = SEG7_BASE;
        biu_wdata = history;
        if (biu_en) begin
          state_d = TXST;
        end
      end
      TXST: begin
        if (rd_done && !biu_rdata[STAT_TXFF_BIT]) begin
          state_d = TXWR;
        end
      end
      TXWR: begin
        biu_we    = 1'b1;
        biu_addr  = UART_DATA;
        biu_wdata = DATA_WIDTH'(pop_byte);
        if (biu_en) begin
          pop     = 1'b1;
          state_d = (count == CW'(1)) ? RXST : TXST;
        end
      end
      default: state_d = RXST;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= RXST;
      req_pending  <= 1'b0;
      history      <= '0;
      o_echo_count <= '0;
      o_overrun    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (biu_en && !biu_we) begin
        req_pending <= 1'b1;
      end else if (biu_valid) begin
        req_pending <= 1'b0;
      end
      if (push) begin
        history <= (history << DATA_BITS) | DATA_WIDTH'(push_byte);
      end
      if (pop) begin
        o_echo_count <= o_echo_count + 16'd1;
      end
      if (set_overrun) begin
        o_overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_echo_master.sv
// Randomized scoreboard bench: UART/seg7 bus slave model plus burst-level reference model.
module tb_uart_echo_master;

  localparam int unsigned D         = 4;
  localparam logic [31:0] UART_BASE = 32'hc0000000;
  localparam logic [31:0] SEG7_BASE = 32'hc0001000;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        o_busy;
  logic [15:0] o_echo_count;
  logic        o_overrun;

  bus_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  uart_echo_master #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .DATA_BITS     (8),
    .BUF_DEPTH     (D),
    .UART_BASE     (UART_BASE),
    .SEG7_BASE     (SEG7_BASE),
    .STAT_RXFE_BIT (0),
    .STAT_TXFF_BIT (1)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .bus          (bus),
    .o_busy       (o_busy),
    .o_echo_count (o_echo_count),
    .o_overrun    (o_overrun)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  rx_q[$];
  logic [63:0] exp_q[$];
  int          txff_polls = 0;
  bit          last_txff = 1'b0;
  bit          stall_seg7 = 1'b0;
  bit          wr_fire = 1'b0;
  logic [31:0] wr_addr, wr_data;

  // Reference model state
  logic [31:0] m_hist = '0;
  logic [15:0] m_total = '0;
  bit          m_overrun = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  function automatic logic [7:0] xf(input logic [7:0] v);
`ifdef UART_ECHO_UPCASE_EN
    if (v >= 8'h61 && v <= 8'h7a) return v - 8'h20;
`endif
    return v;
  endfunction

  // Bus slave: UART status/data registers and seg7 sink, random ack latency.
  initial begin
    int lat;
    logic [31:0] st;
    lat = -1;
    bus.ack = 1'b0;
    bus.rdata = '0;
    forever begin
      @(negedge clk);
      bus.ack = 1'b0;
      wr_fire = 1'b0;
      if (!n_rst) begin
        lat = -1;
      end else if (bus.req) begin
        if (lat < 0) begin
          lat = (bus.we && bus.addr == SEG7_BASE && stall_seg7) ? 20 : int'($urandom_range(0, 3));
        end
        if (lat == 0) begin
          lat = -1;
          bus.ack = 1'b1;
          if (bus.we) begin
            wr_fire = 1'b1;
            wr_addr = bus.addr;
            wr_data = bus.wdata;
            if (bus.addr == UART_BASE) check("tx_while_full", 32'(last_txff), 32'd0);
          end else if (bus.addr == UART_BASE + 32'd8) begin
            st = '0;
            st[0] = (rx_q.size() == 0);
            st[1] = (txff_polls > 0);
            last_txff = st[1];
            if (txff_polls > 0) txff_polls--;
            bus.rdata = st;
          end else if (bus.addr == UART_BASE) begin
            if (rx_q.size() == 0) begin
              errors++;
              $display("FAIL rx_underflow got=read_of_empty want=no_read");
              bus.rdata = '0;
            end else begin
              bus.rdata = {24'h0, rx_q.pop_front()};
            end
          end else begin
            bus.rdata = '0;
          end
        end else begin
          lat--;
        end
      end
    end
  end

  // Monitor: every acked write is compared against the scoreboard head.
  initial begin
    logic [63:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (wr_fire) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write got=%h:%h want=none", wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          if ({wr_addr, wr_data} !== e) begin
            errors++;
            $display("FAIL write got=%h:%h want=%h:%h", wr_addr, wr_data, e[63:32], e[31:0]);
          end
        end
      end
    end
  end

  // Burst model: each burst takes up to D bytes, then seg7 gets the history, then echoes.
  task automatic model_group(input logic [7:0] b[$]);
    int idx;
    int k;
    logic [7:0] v;
    logic [7:0] tx[$];
    idx = 0;
    while (idx < b.size()) begin
      k = (b.size() - idx > D) ? D : b.size() - idx;
      if (b.size() - idx > D) m_overrun = 1'b1;
      tx.delete();
      for (int j = 0; j < k; j++) begin
        v = xf(b[idx + j]);
        m_hist = {m_hist[23:0], v};
        tx.push_back(v);
      end
      exp_q.push_back({SEG7_BASE, m_hist});
      foreach (tx[j]) exp_q.push_back({UART_BASE, 24'h0, tx[j]});
      m_total += 16'(k);
      idx += k;
    end
  endtask

  task automatic wait_idle(input string name);
    int ok;
    ok = 0;
    for (int i = 0; i < 4000 && ok < 3; i++) begin
      @(posedge clk);
      #1;
      if (rx_q.size() == 0 && exp_q.size() == 0 && !o_busy) ok++;
      else ok = 0;
    end
    if (ok < 3) begin
      errors++;
      $display("FAIL %s_timeout got=pending:%0d want=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_group(input logic [7:0] b[$], input int polls, input bit stall);
    @(posedge clk);
    #1;
    txff_polls = polls;
    stall_seg7 = stall;
    model_group(b);
    foreach (b[i]) rx_q.push_back(b[i]);
    wait_idle("group");
    check("echo_count", 32'(o_echo_count), 32'(m_total));
    check("overrun", 32'(o_overrun), 32'(m_overrun));
    check("busy_idle", 32'(o_busy), 32'd0);
  endtask

  initial begin
    logic [7:0] g[$];
    bit seen;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_count", 32'(o_echo_count), 32'd0);
    check("rst_overrun", 32'(o_overrun), 32'd0);
    check("rst_req", 32'(bus.req), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;

    g = '{8'h41};                             run_group(g, 0, 1'b0);
    g = '{8'h31, 8'h32, 8'h33};               run_group(g, 0, 1'b0);
    g = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    run_group(g, 0, 1'b0);
    g = '{8'h51, 8'h52, 8'h53};               run_group(g, 10, 1'b0);
    g = '{8'h71, 8'h72};                      run_group(g, 0, 1'b1);
    g = '{8'h61, 8'h7a, 8'h5b};               run_group(g, 0, 1'b0);
    g = '{8'ha0, 8'ha1, 8'ha2, 8'ha3};        run_group(g, 2, 1'b0);

    for (int n = 0; n < 8; n++) begin
      g.delete();
      for (int i = 0; i < int'($urandom_range(1, 9)); i++) g.push_back(8'($urandom_range(0, 255)));
      run_group(g, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    end

    // Reset while a TX data write is in flight.
    @(posedge clk);
    #1;
    txff_polls = 0;
    stall_seg7 = 1'b0;
    g = '{8'h21, 8'h22, 8'h23};
    model_group(g);
    foreach (g[i]) rx_q.push_back(g[i]);
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (bus.req && bus.we && bus.addr == UART_BASE) seen = 1'b1;
    end
    check("reset_trigger_seen", 32'(seen), 32'd1);
    @(posedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    check("midrst_count", 32'(o_echo_count), 32'd0);
    check("midrst_overrun", 32'(o_overrun), 32'd0);
    check("midrst_busy", 32'(o_busy), 32'd0);
    check("midrst_req", 32'(bus.req), 32'd0);
    exp_q.delete();
    rx_q.delete();
    m_hist = '0;
    m_total = '0;
    m_overrun = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_rst = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("post_rst_count", 32'(o_echo_count), 32'd0);
    check("post_rst_busy", 32'(o_busy), 32'd0);

    g = '{8'h41, 8'h42};                      run_group(g, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
